// File: rtl/apb_slave_mem_param.sv
// Word-addressed APB slave memory with range-checked pslverror; optional byte strobes via APB_PSTRB_EN.
// Latency: pready rises WAIT_STATES+1 cycles after the SETUP edge, high for exactly one cycle.
// Backpressure: inserts WAIT_STATES wait cycles per transfer; a dropped pselx aborts with no response.
module apb_slave_mem_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverror
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]          WS        = 4'(WAIT_STATES);

  // SETUP is kept as a named encoding; a SETUP phase is recognised directly
  // from the bus in any state, so the register never needs to hold it.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] strb_q;
`endif
  logic [3:0]              cnt_q, cnt_d;
  logic                    pready_d, pslverror_d;
  logic [DATA_WIDTH-1:0]   prdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // A SETUP phase restarts the transfer; its address is used directly when
  // there are no wait states, otherwise the latched address is used.
  logic                    setup_evt;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [ADDR_WIDTH:0]     acc_diff;
  logic                    acc_err;
  logic [IDX_W-1:0]        acc_idx;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    mem_we;

  assign setup_evt = pselx & ~penable;
  assign acc_addr  = setup_evt ? paddr : addr_q;
  // One extra bit keeps addresses below BASE_ADDR negative instead of wrapping.
  assign acc_diff  = {1'b0, acc_addr} - BASE_EXT;
  assign acc_err   = !(acc_diff < DEPTH_EXT);
  assign acc_idx   = acc_diff[IDX_W-1:0];
  assign rd_val    = acc_err ? '0 : mem[acc_idx];
  assign mem_we    = (state_q == ACCESS) & pselx & penable & pready & write_q & ~acc_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: SETUP enters ACCESS; completion or a dropped select returns to IDLE
  always_comb begin
    state_d = state_q;
    if (setup_evt) begin
      state_d = ACCESS;
    end else if (state_q == ACCESS) begin
      if (!pselx || pready) state_d = IDLE;
    end else begin
      state_d = IDLE;
    end
  end

  // Output/next-value logic for the registered response and the wait counter
  always_comb begin
    pready_d    = 1'b0;
    pslverror_d = 1'b0;
    prdata_d    = prdata;
    cnt_d       = cnt_q;
    if (setup_evt) begin
      cnt_d = WS;
      if (WS == 4'd0) begin
        pready_d    = 1'b1;
        pslverror_d = acc_err;
        if (!pwrite) prdata_d = rd_val;
      end
    end else if (state_q == ACCESS && pselx && penable && !pready) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        pready_d    = 1'b1;
        pslverror_d = acc_err;
        if (!write_q) prdata_d = rd_val;
      end
    end else if (state_q == ACCESS && pselx && penable) begin
      cnt_d = 4'd0;
    end
  end

  // Response registers and transfer context captured at SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pready    <= 1'b0;
      pslverror <= 1'b0;
      prdata    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
`ifdef APB_PSTRB_EN
      strb_q    <= '0;
`endif
    end else begin
      pready    <= pready_d;
      pslverror <= pslverror_d;
      prdata    <= prdata_d;
      cnt_q     <= cnt_d;
      if (setup_evt) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
`ifdef APB_PSTRB_EN
        strb_q  <= pstrb;
`endif
      end
    end
  end

`ifdef APB_PSTRB_EN
  // Memory write on completion, per enabled byte lane; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (strb_q[i]) mem[acc_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end
`else
  // Memory write on completion, full word; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= wdata_q;
  end
`endif

endmodule
